// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, one-hot T-state encoding and opcode class helper.
package sap1_pkg;

    localparam logic [3:0] OPC_LDA = 4'h0;
    localparam logic [3:0] OPC_ADD = 4'h1;
    localparam logic [3:0] OPC_SUB = 4'h2;
    localparam logic [3:0] OPC_OUT = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef logic [5:0] tstate_t;

    localparam tstate_t T1 = 6'b000001;
    localparam tstate_t T2 = 6'b000010;
    localparam tstate_t T3 = 6'b000100;
    localparam tstate_t T4 = 6'b001000;
    localparam tstate_t T5 = 6'b010000;
    localparam tstate_t T6 = 6'b100000;

    // Opcodes that fetch an operand byte from ROM during T5.
    function automatic logic is_mem_ref(input logic [3:0] opcode);
        return (opcode == OPC_LDA) || (opcode == OPC_ADD) || (opcode == OPC_SUB);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot ring counter sequencing T1..T6; rotates left on advance.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       clr_bar,
    input  logic       advance,
    output logic [5:0] t_state
);

    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar)
            t_state <= T1;
        else if (advance)
            t_state <= {t_state[4:0], t_state[5]};
    end

endmodule

// File: rtl/sap1_fetch_unit.sv
// SAP-1 fetch side: PC, MAR, ring counter, ROM chip enable, instruction and operand latches.
module sap1_fetch_unit
    import sap1_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              clr_bar,
    input  logic              run,
    output logic [ADDR_W-1:0] rom_address,
    output logic              rom_CE_bar,
    input  logic [DATA_W-1:0] rom_data,
    output logic [5:0]        t_state,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic [DATA_W-1:0] operand,
    output logic              operand_valid,
    output logic              halted
);

    logic [ADDR_W-1:0] mar;
    logic              advance;
    logic              mem_ref;
    logic              is_hlt;

    assign advance     = run & ~halted;
    assign mem_ref     = is_mem_ref(instr[DATA_W-1 -: 4]);
    assign is_hlt      = (instr[DATA_W-1 -: 4] == OPC_HLT);
    assign rom_address = mar;

    sap1_ring_counter u_ring (
        .clk     (clk),
        .clr_bar (clr_bar),
        .advance (advance),
        .t_state (t_state)
    );

    // CE_bar is computed for the state being entered, so it holds across a freeze
    // and the pending access completes once run returns.
    always_ff @(posedge clk or negedge clr_bar) begin
        if (!clr_bar) begin
            pc            <= '0;
            mar           <= '0;
            rom_CE_bar    <= 1'b1;
            instr         <= '0;
            operand       <= '0;
            instr_valid   <= 1'b0;
            operand_valid <= 1'b0;
            halted        <= 1'b0;
        end else begin
            instr_valid   <= 1'b0;
            operand_valid <= 1'b0;
            if (advance) begin
                rom_CE_bar <= 1'b1;
                if (t_state == T1)
                    mar <= pc;
                if (t_state == T2) begin
                    pc         <= pc + 1'b1;
                    rom_CE_bar <= 1'b0;
                end
                if (t_state == T3) begin
                    instr       <= rom_data;
                    instr_valid <= 1'b1;
                end
                if (t_state == T4) begin
                    if (mem_ref) begin
                        mar        <= instr[ADDR_W-1:0];
                        rom_CE_bar <= 1'b0;
                    end
                    if (is_hlt)
                        halted <= 1'b1;
                end
                if (t_state == T5 && mem_ref) begin
                    operand       <= rom_data;
                    operand_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sap1_fetch_unit.sv
// Scoreboard bench for sap1_fetch_unit: per-cycle fetch timing plus queued instr/operand checks.
module tb_sap1_fetch_unit;

    logic       tb_clk = 1'b0;
    logic       clr_bar = 1'b0;
    logic       run = 1'b0;
    logic [3:0] rom_address;
    logic       rom_CE_bar;
    logic [7:0] rom_data;
    logic [5:0] t_state;
    logic [3:0] pc;
    logic [7:0] instr;
    logic       instr_valid;
    logic [7:0] operand;
    logic       operand_valid;
    logic       halted;

    logic [7:0] rom [16];
    logic [7:0] instr_q [$];
    logic [7:0] opnd_q [$];
    int         n_chk = 0;
    int         n_err = 0;
    int         ce_run_cnt = 0;

    assign rom_data = rom[rom_address];

    always #5 tb_clk = ~tb_clk;

    sap1_fetch_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk           (tb_clk),
        .clr_bar       (clr_bar),
        .run           (run),
        .rom_address   (rom_address),
        .rom_CE_bar    (rom_CE_bar),
        .rom_data      (rom_data),
        .t_state       (t_state),
        .pc            (pc),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .operand       (operand),
        .operand_valid (operand_valid),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Continuous monitor: scoreboard pops plus structural invariants.
    always @(negedge tb_clk) begin
        chk("onehot", {31'b0, $onehot(t_state)}, 1);
        ce_run_cnt = (!rom_CE_bar && run) ? ce_run_cnt + 1 : 0;
        chk("ce_pulse_len", {31'b0, ce_run_cnt > 1}, 0);
        if (!rom_CE_bar)
            chk("ce_state", {31'b0, (t_state == 6'b000100) || (t_state == 6'b010000)}, 1);
        if (instr_valid) begin
            if (instr_q.size() == 0) chk("instr_extra", 1, 0);
            else                     chk("instr_sb", instr, instr_q.pop_front());
        end
        if (operand_valid) begin
            if (opnd_q.size() == 0) chk("opnd_extra", 1, 0);
            else                    chk("opnd_sb", operand, opnd_q.pop_front());
        end
    end

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tstate"}, t_state, 6'b000001);
        chk({tag, "_pc"}, pc, 0);
        chk({tag, "_mar"}, rom_address, 0);
        chk({tag, "_ce"}, rom_CE_bar, 1);
        chk({tag, "_instr"}, instr, 0);
        chk({tag, "_opnd"}, operand, 0);
        chk({tag, "_ivld"}, instr_valid, 0);
        chk({tag, "_ovld"}, operand_valid, 0);
        chk({tag, "_halt"}, halted, 0);
    endtask

    task automatic do_reset();
        clr_bar = 1'b0;
        run     = 1'b0;
        step();
        chk_reset_vals("rst");
        clr_bar = 1'b1;
        run     = 1'b1;
    endtask

    task automatic rom_clear();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    // Runs one instruction starting in T1; for HLT stops in T5 after checking halted.
    task automatic run_instr(input logic [7:0] ins, input logic [7:0] opnd, input logic [3:0] pc0);
        logic       mem;
        logic       hlt;
        logic [3:0] pc1;
        mem = (ins[7:4] == 4'h0) || (ins[7:4] == 4'h1) || (ins[7:4] == 4'h2);
        hlt = (ins[7:4] == 4'hF);
        pc1 = pc0 + 4'd1;
        instr_q.push_back(ins);
        if (mem) opnd_q.push_back(opnd);
        for (int c = 1; c <= 6; c++) begin
            chk("t_state", t_state, 32'(1) << (c - 1));
            chk("ce", rom_CE_bar, (c == 3 || (c == 5 && mem)) ? 0 : 1);
            chk("pc", pc, (c >= 3) ? pc1 : pc0);
            if (c == 2 || c == 3) chk("mar_fetch", rom_address, pc0);
            if (c == 5 && mem)    chk("mar_opnd", rom_address, ins[3:0]);
            if (c == 4) begin
                chk("instr", instr, ins);
                chk("instr_valid", instr_valid, 1);
            end
            if (c == 6 && mem) begin
                chk("operand", operand, opnd);
                chk("operand_valid", operand_valid, 1);
            end
            if (c == 5 && hlt) begin
                chk("halted", halted, 1);
                return;
            end
            step();
        end
    endtask

    initial begin
        rom_clear();

        // Single LDA fetch
        rom[0] = 8'h09;
        rom[9] = 8'h5A;
        do_reset();
        run_instr(8'h09, 8'h5A, 4'd0);

        // Short program ending in HLT
        rom_clear();
        rom[0] = 8'h09; rom[1] = 8'h1A; rom[2] = 8'hE0; rom[3] = 8'hF0;
        rom[9] = 8'h10; rom[10] = 8'h07;
        do_reset();
        run_instr(8'h09, 8'h10, 4'd0);
        run_instr(8'h1A, 8'h07, 4'd1);
        run_instr(8'hE0, 8'h00, 4'd2);
        run_instr(8'hF0, 8'h00, 4'd3);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("hlt_tstate", t_state, 6'b010000);
            chk("hlt_pc", pc, 4);
            chk("hlt_ce", rom_CE_bar, 1);
            chk("hlt_sticky", halted, 1);
        end
        chk("hlt_opnd_hold", operand, 8'h07);

        // PC wrap with non-memory opcodes
        for (int i = 0; i < 16; i++) rom[i] = 8'hE0;
        do_reset();
        for (int i = 0; i < 17; i++) run_instr(8'hE0, 8'h00, 4'(i));

        // Freeze during T3
        rom_clear();
        rom[0] = 8'h2B;
        rom[11] = 8'h33;
        do_reset();
        instr_q.push_back(8'h2B);
        opnd_q.push_back(8'h33);
        step();
        step();
        run = 1'b0;
        chk("frz_ce_entry", rom_CE_bar, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("frz_ce", rom_CE_bar, 0);
            chk("frz_tstate", t_state, 6'b000100);
            chk("frz_instr", instr, 0);
            chk("frz_ivld", instr_valid, 0);
            chk("frz_pc", pc, 1);
        end
        run = 1'b1;
        step();
        chk("rel_instr", instr, 8'h2B);
        chk("rel_ivld", instr_valid, 1);
        chk("rel_tstate", t_state, 6'b001000);
        step();
        chk("rel_ivld_once", instr_valid, 0);
        chk("rel_ce_t5", rom_CE_bar, 0);
        step();
        chk("rel_opnd", operand, 8'h33);
        chk("rel_ovld", operand_valid, 1);
        step();

        // Async reset mid-T5 of an ADD
        rom_clear();
        rom[0] = 8'h1C;
        rom[12] = 8'h44;
        do_reset();
        instr_q.push_back(8'h1C);
        for (int i = 0; i < 4; i++) step();
        chk("mid_t5_ce", rom_CE_bar, 0);
        #2;
        clr_bar = 1'b0;
        #1;
        chk_reset_vals("async");
        do_reset();
        run_instr(8'h1C, 8'h44, 4'd0);

        chk("instr_q_empty", instr_q.size(), 0);
        chk("opnd_q_empty", opnd_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
